// File: rtl/user2xport_pkg.sv
// user2xport_pkg: shared FSM states, miss-policy constants and saturating counter helper.
package user2xport_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_PASS, ST_DROP} state_t;

    localparam int MISS_DROP    = 0;
    localparam int MISS_DEFAULT = 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/user2xport_mc_rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from last_grant+1, one-hot and index outputs.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant_oh,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_valid
);

    logic [ID_W-1:0] c;

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        c           = '0;
        for (int i = 1; i <= N; i++) begin
            c = ID_W'((int'(last_grant) + i) % N);
            if (!grant_valid && req[c]) begin
                grant_valid = 1'b1;
                grant_oh[c] = 1'b1;
                grant_idx   = c;
            end
        end
    end

endmodule

// File: rtl/user2xport_mc.sv
// user2xport_mc: round-robin merges NUM_IN keyed CHDR streams, one kv_map lookup per packet,
// forwards with the looked-up route on tuser; misses/timeouts are dropped or default-routed.
module user2xport_mc
    import user2xport_pkg::*;
#(
    parameter int               CHDR_W      = 64,
    parameter int               KEY_W       = 16,
    parameter int               VAL_W       = 112,
    parameter int               NUM_IN      = 4,
    parameter int               MISS_MODE   = 0,
    parameter logic [VAL_W-1:0] DEFAULT_VAL = '0,
    parameter int               TIMEOUT     = 255,
    localparam int              ID_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*CHDR_W-1:0] s_tdata,
    input  logic [NUM_IN*KEY_W-1:0]  s_tuser,
    input  logic [NUM_IN-1:0]        s_tvalid,
    input  logic [NUM_IN-1:0]        s_tlast,
    output logic [NUM_IN-1:0]        s_tready,
    output logic [CHDR_W-1:0]        x2e_tdata,
    output logic [VAL_W-1:0]         x2e_tuser,
    output logic [ID_W-1:0]          x2e_tid,
    output logic                     x2e_tvalid,
    output logic                     x2e_tlast,
    input  logic                     x2e_tready,
    output logic                     find_key_stb,
    output logic [KEY_W-1:0]         find_key,
    input  logic                     kv_map_busy,
    input  logic                     find_res_stb,
    input  logic                     find_res_match,
    input  logic [VAL_W-1:0]         find_res_value,
    output logic [31:0]              drop_count,
    output logic [31:0]              miss_count
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    sel_q, sel_d, last_q, last_d;
    logic [KEY_W-1:0]   key_q, key_d, gnt_key;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [31:0]        timer_q, timer_d, drop_q, drop_d, miss_q, miss_d;
    logic [NUM_IN-1:0]  gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid, cur_valid, cur_last;

    rr_arbiter #(.N(NUM_IN), .ID_W(ID_W)) u_arb (
        .req         (s_tvalid),
        .last_grant  (last_q),
        .grant_oh    (gnt_oh),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    always_comb begin
        gnt_key = '0;
        for (int i = 0; i < NUM_IN; i++)
            gnt_key |= gnt_oh[i] ? s_tuser[i*KEY_W +: KEY_W] : '0;
    end

    assign cur_valid  = s_tvalid[sel_q];
    assign cur_last   = s_tlast[sel_q];
    assign find_key   = key_q;
    assign drop_count = drop_q;
    assign miss_count = miss_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        key_d        = key_q;
        val_d        = val_q;
        timer_d      = timer_q;
        drop_d       = drop_q;
        miss_d       = miss_q;
        find_key_stb = 1'b0;
        s_tready     = '0;
        x2e_tvalid   = 1'b0;
        x2e_tlast    = 1'b0;
        x2e_tdata    = '0;
        x2e_tuser    = '0;
        x2e_tid      = '0;
        case (state_q)
            ST_IDLE: if (gnt_valid) begin
                sel_d   = gnt_idx;
                key_d   = gnt_key;
                state_d = ST_REQ;
            end
            ST_REQ: if (!kv_map_busy) begin
                find_key_stb = 1'b1;
                timer_d      = 32'(TIMEOUT);
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q - 32'd1;
                // a result arriving on the expiry cycle takes priority over the timeout
                if (find_res_stb && find_res_match) begin
                    val_d   = find_res_value;
                    state_d = ST_PASS;
                end else if (find_res_stb || timer_q == 32'd1) begin
                    miss_d  = sat_inc(miss_q);
                    val_d   = DEFAULT_VAL;
                    state_d = (MISS_MODE == MISS_DEFAULT) ? ST_PASS : ST_DROP;
                end
            end
            ST_PASS: begin
                x2e_tvalid      = cur_valid;
                x2e_tlast       = cur_last;
                x2e_tdata       = s_tdata[sel_q*CHDR_W +: CHDR_W];
                x2e_tuser       = val_q;
                x2e_tid         = sel_q;
                s_tready[sel_q] = x2e_tready;
                if (cur_valid && x2e_tready && cur_last) begin
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_tready[sel_q] = 1'b1;
                if (cur_valid && cur_last) begin
                    drop_d  = sat_inc(drop_q);
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= ID_W'(NUM_IN - 1);
            key_q   <= '0;
            val_q   <= '0;
            timer_q <= '0;
            drop_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            key_q   <= key_d;
            val_q   <= val_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            miss_q  <= miss_d;
        end
    end

endmodule

// File: tb/tb_user2xport_mc.sv
// tb_user2xport_mc: directed checks of routing, round robin, miss/timeout policy, busy,
// backpressure and asynchronous reset; dut0 drops on miss, dut1 default-routes.
module tb_user2xport_mc;

    localparam int N = 4, CW = 64, KW = 16, VW = 112;
    localparam logic [VW-1:0] DEF = 112'hDEF0;

    logic clk = 1'b0;
    logic rst0, rst1, m;
    logic [N*CW-1:0] s_tdata;
    logic [N*KW-1:0] s_tuser;
    logic [N-1:0] s_tvalid, s_tlast, rdy0, rdy1, o_rdy;
    logic [CW-1:0] d0, d1, o_d;
    logic [VW-1:0] u0, u1, o_u, res_val;
    logic [1:0] id0, id1, o_id;
    logic v0, v1, l0, l1, o_v, o_l, stb0, stb1, o_stb, x2e_tready, busy, res_stb, res_match;
    logic [KW-1:0] fk0, fk1, o_fk;
    logic [31:0] dc0, dc1, mc0, mc1, o_dc, o_mc;

    assign o_rdy = m ? rdy1 : rdy0;
    assign o_d   = m ? d1 : d0;
    assign o_u   = m ? u1 : u0;
    assign o_id  = m ? id1 : id0;
    assign o_v   = m ? v1 : v0;
    assign o_l   = m ? l1 : l0;
    assign o_stb = m ? stb1 : stb0;
    assign o_fk  = m ? fk1 : fk0;
    assign o_dc  = m ? dc1 : dc0;
    assign o_mc  = m ? mc1 : mc0;

    user2xport_mc #(.MISS_MODE(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst0), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(rdy0), .x2e_tdata(d0), .x2e_tuser(u0), .x2e_tid(id0),
        .x2e_tvalid(v0), .x2e_tlast(l0), .x2e_tready(x2e_tready), .find_key_stb(stb0),
        .find_key(fk0), .kv_map_busy(busy), .find_res_stb(res_stb), .find_res_match(res_match),
        .find_res_value(res_val), .drop_count(dc0), .miss_count(mc0));

    user2xport_mc #(.MISS_MODE(1), .TIMEOUT(8), .DEFAULT_VAL(DEF)) dut1 (
        .clk(clk), .rst(rst1), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(rdy1), .x2e_tdata(d1), .x2e_tuser(u1), .x2e_tid(id1),
        .x2e_tvalid(v1), .x2e_tlast(l1), .x2e_tready(x2e_tready), .find_key_stb(stb1),
        .find_key(fk1), .kv_map_busy(busy), .find_res_stb(res_stb), .find_res_match(res_match),
        .find_res_value(res_val), .drop_count(dc1), .miss_count(mc1));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int len[N], pos[N], npk[N], pk[N], consumed[N];
    logic [KW-1:0] key[N];
    logic [KW-1:0] mkey;
    int cy, stbs, stb_cy, first_cy, viol, lat, rcnt, busy_cnt;
    bit silent, bp;
    logic [95:0] kv_hi;
    logic kv_match;
    logic [CW-1:0] q_data[$];
    logic [VW-1:0] q_user[$];
    logic [1:0] q_tid[$];
    logic q_last[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] beat(input int ch, input int p, input int b);
        return {8'(ch), 8'(p), 32'h0, 16'(b)};
    endfunction

    // one clock: drive at negedge, sample 1ns later, book the handshakes the next posedge commits
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = npk[i] > 0;
            s_tlast[i] = pos[i] == len[i] - 1;
            s_tdata[i*CW +: CW] = beat(i, pk[i], pos[i]);
            s_tuser[i*KW +: KW] = key[i];
        end
        x2e_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        busy = busy_cnt > 0;
        if (busy_cnt > 0) busy_cnt--;
        res_stb = rcnt == 1;
        res_match = kv_match;
        res_val = {kv_hi, mkey};
        if (rcnt > 0) rcnt--;
        #1;
        if (o_stb) begin
            if (stbs == 0) stb_cy = cy;
            stbs++;
            mkey = o_fk;
            if (!silent) rcnt = lat;
        end
        if (o_v && x2e_tready) begin
            if (first_cy < 0) first_cy = cy;
            q_data.push_back(o_d);
            q_user.push_back(o_u);
            q_tid.push_back(o_id);
            q_last.push_back(o_l);
        end
        if (o_v && o_rdy !== (4'(x2e_tready) << o_id)) viol++;
        if ($countones(o_rdy) > 1) viol++;
        for (int i = 0; i < N; i++)
            if (s_tvalid[i] && o_rdy[i]) begin
                consumed[i]++;
                if (pos[i] == len[i] - 1) begin
                    pos[i] = 0;
                    npk[i]--;
                    pk[i]++;
                end else pos[i]++;
            end
        cy++;
    endtask

    task automatic do_reset(input bit which);
        m = which;
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < N; i++) begin
            len[i] = 1; pos[i] = 0; npk[i] = 0; pk[i] = 0; consumed[i] = 0; key[i] = '0;
        end
        rcnt = 0; busy_cnt = 0; silent = 0; bp = 0; lat = 2; kv_match = 1'b1; kv_hi = '0;
        stbs = 0; first_cy = -1; stb_cy = -1; viol = 0; mkey = '0;
        q_data.delete(); q_user.delete(); q_tid.delete(); q_last.delete();
        @(negedge clk);
        s_tvalid = '0; busy = 1'b0; res_stb = 1'b0; x2e_tready = 1'b1;
        #2;
        if (which) rst1 = 1'b0; else rst0 = 1'b0;
        cy = 0;
    endtask

    initial begin
        int tids[5] = '{0, 1, 2, 3, 0};
        int pks[5]  = '{0, 0, 0, 0, 1};
        m = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
        s_tdata = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0;
        x2e_tready = 1'b1; busy = 1'b0; res_stb = 1'b0; res_match = 1'b0; res_val = '0;
        #3;
        chk("rst_tvalid", o_v, 0);
        chk("rst_tlast", o_l, 0);
        chk("rst_tuser", o_u, 0);
        chk("rst_tid", o_id, 0);
        chk("rst_tready", o_rdy, 0);
        chk("rst_stb", o_stb, 0);
        chk("rst_key", o_fk, 0);
        chk("rst_drop", o_dc, 0);
        chk("rst_miss", o_mc, 0);

        // round robin: all channels busy, channel 0 has a second packet
        do_reset(0);
        for (int i = 0; i < N; i++) begin npk[i] = 1; len[i] = 2; key[i] = 16'h0100 + 16'(i); end
        npk[0] = 2; lat = 1; kv_hi = 96'h5A;
        repeat (60) cyc();
        chk("rr_beats", q_data.size(), 10);
        for (int k = 0; k < 5; k++)
            for (int b = 0; b < 2; b++) begin
                chk("rr_beat", {q_tid[2*k+b], q_last[2*k+b], q_data[2*k+b]},
                    {2'(tids[k]), b == 1, beat(tids[k], pks[k], b)});
                chk("rr_tuser", q_user[2*k+b], {96'h5A, 16'h0100 + 16'(tids[k])});
            end
        chk("rr_stbs", stbs, 5);
        chk("rr_viol", viol, 0);

        // single hit, lookup answers two cycles after the request
        do_reset(0);
        npk[0] = 1; len[0] = 4; key[0] = 16'h0012; kv_hi = 96'hAB;
        repeat (20) cyc();
        chk("hit_stbs", stbs, 1);
        chk("hit_key", mkey, 16'h0012);
        chk("hit_latency", first_cy - stb_cy, 3);
        chk("hit_beats", q_data.size(), 4);
        for (int b = 0; b < 4; b++)
            chk("hit_beat", {q_tid[b], q_last[b], q_user[b], q_data[b]},
                {2'd0, b == 3, {96'hAB, 16'h0012}, beat(0, 0, b)});

        // miss with drop policy
        do_reset(0);
        npk[2] = 1; len[2] = 5; key[2] = 16'h0222; kv_match = 1'b0;
        repeat (25) cyc();
        chk("miss_out", q_data.size(), 0);
        chk("miss_consumed", consumed[2], 5);
        chk("miss_drop", o_dc, 1);
        chk("miss_miss", o_mc, 1);

        // timeout with drop policy
        do_reset(0);
        npk[0] = 1; len[0] = 2; key[0] = 16'h0055; silent = 1;
        repeat (30) cyc();
        chk("to_drop_out", q_data.size(), 0);
        chk("to_drop_drop", o_dc, 1);
        chk("to_drop_miss", o_mc, 1);

        // busy delays the request; random backpressure over two packets
        do_reset(0);
        npk[3] = 2; len[3] = 6; key[3] = 16'h0333; busy_cnt = 11; bp = 1; kv_hi = 96'h33;
        repeat (150) cyc();
        chk("busy_stb_cycle", stb_cy, 11);
        chk("bp_stbs", stbs, 2);
        chk("bp_beats", q_data.size(), 12);
        for (int k = 0; k < 12; k++)
            chk("bp_beat", {q_tid[k], q_last[k], q_user[k], q_data[k]},
                {2'd3, (k % 6) == 5, {96'h33, 16'h0333}, beat(3, k / 6, k % 6)});
        chk("bp_tready_mirror", viol, 0);

        // timeout with default-route policy
        do_reset(1);
        npk[1] = 1; len[1] = 3; key[1] = 16'h0111; silent = 1;
        repeat (40) cyc();
        chk("to_def_latency", first_cy - stb_cy, 9);
        chk("to_def_beats", q_data.size(), 3);
        for (int b = 0; b < 3; b++)
            chk("to_def_beat", {q_tid[b], q_last[b], q_user[b], q_data[b]},
                {2'd1, b == 2, DEF, beat(1, 0, b)});
        chk("to_def_miss", o_mc, 1);
        chk("to_def_drop", o_dc, 0);

        // asynchronous reset in the middle of an output packet
        do_reset(0);
        npk[1] = 1; len[1] = 6; key[1] = 16'h0444; lat = 1; kv_hi = 96'h77;
        for (int k = 0; k < 30 && q_data.size() < 2; k++) cyc();
        chk("ar_pre_beats", q_data.size(), 2);
        @(posedge clk);
        #2;
        chk("ar_pre_valid", o_v, 1);
        rst0 = 1'b1;
        #1;
        chk("ar_valid", o_v, 0);
        chk("ar_tready", o_rdy, 0);
        chk("ar_tuser", o_u, 0);
        chk("ar_tid", o_id, 0);
        #10;
        rst0 = 1'b0;
        q_data.delete(); q_user.delete(); q_tid.delete(); q_last.delete();
        repeat (20) cyc();
        chk("ar_stbs", stbs, 2);
        chk("ar_post_beats", q_data.size(), 4);
        for (int b = 0; b < 4; b++)
            chk("ar_post_beat", {q_tid[b], q_last[b], q_user[b], q_data[b]},
                {2'd1, b == 3, {96'h77, 16'h0444}, beat(1, 0, b + 2)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
